// File: rtl/remote_pkg.sv
// remote_pkg: shared types and constants for the remote command scheduler
package remote_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_SNT, WAIT_RESP} sched_state_t;
  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam int CMD_W = 16;
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: command FIFO with a registered head word
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr, cnt;
  logic [AW-1:0] nxt;
  logic do_push, do_pop;
  assign cnt = wptr - rptr;
  assign nxt = rptr[AW-1:0] + AW'(1);
  assign empty = wptr == rptr;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk)
    if (do_push) mem[wptr[AW-1:0]] <= din;
  // the head register tracks the oldest entry, bypassing din when it becomes the head
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      dout <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      if (do_push && (empty || (do_pop && cnt == (AW+1)'(1)))) dout <= din;
      else if (do_pop && cnt > (AW+1)'(1)) dout <= mem[nxt];
    end
endmodule

// File: rtl/remote_cmd_sched.sv
// remote_cmd_sched: queues knight commands and sends them with ACK/retry handling
module remote_cmd_sched
  import remote_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 2_000_000,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [CMD_W-1:0] push_cmd,
  output logic             full,
  output logic             empty,
  output logic             snd_cmd,
  output logic [CMD_W-1:0] cmd,
  input  logic             cmd_snt,
  input  logic             resp_rdy,
  input  logic [7:0]       resp,
  output logic             clr_resp_rdy,
  output logic             busy,
  output logic             cmd_ok,
  output logic             err
);
  localparam int TW = $clog2(TIMEOUT);
  localparam int RW = $clog2(MAX_RETRY + 1);
  sched_state_t state;
  logic [TW-1:0] tcnt;
  logic [RW-1:0] rcnt;
  logic first, ack, retry, give_up, pop;
  assign ack = state == WAIT_RESP && resp_rdy && resp == RESP_ACK;
  assign retry = state == WAIT_RESP && (resp_rdy ? resp != RESP_ACK : tcnt == TW'(TIMEOUT - 1));
  assign give_up = retry && rcnt >= RW'(MAX_RETRY);
  assign pop = ack || give_up;
  assign snd_cmd = state == LAUNCH;
  assign busy = state != IDLE;
  cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(push_cmd),
    .dout(cmd), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      tcnt <= '0;
      rcnt <= '0;
      first <= 1'b0;
      clr_resp_rdy <= 1'b0;
      cmd_ok <= 1'b0;
      err <= 1'b0;
    end else begin
      // responses are consumed everywhere but LAUNCH; outside WAIT_RESP they are stale
      clr_resp_rdy <= resp_rdy && state != LAUNCH;
      cmd_ok <= ack;
      if (give_up) err <= 1'b1;
      case (state)
        IDLE: if (!empty) begin
          state <= LAUNCH;
          rcnt <= '0;
        end
        LAUNCH: begin
          tcnt <= '0;
          first <= 1'b1;
          state <= WAIT_SNT;
        end
        WAIT_SNT: begin
          first <= 1'b0;
          if (!first && cmd_snt) begin
            state <= WAIT_RESP;
            tcnt <= '0;
          end
        end
        WAIT_RESP: begin
          tcnt <= tcnt + 1'b1;
          if (pop) state <= IDLE;
          else if (retry) begin
            rcnt <= rcnt + 1'b1;
            state <= LAUNCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_remote_cmd_sched.sv
// tb_remote_cmd_sched: randomized self-checking bench with transmitter/receiver models
module tb_remote_cmd_sched;
  localparam int DEPTH = 4, TIMEOUT = 100, MAX_RETRY = 3;
  logic clk = 0, rst_n = 0, push = 0;
  logic [15:0] push_cmd = 0, cmd;
  logic full, empty, snd_cmd, cmd_snt, resp_rdy, clr_resp_rdy, busy, cmd_ok, err;
  logic [7:0] resp;
  int errors = 0, checks = 0;
  logic hold_tx = 0;
  int tx_fixed = 0;
  int plan[$];
  logic [15:0] sent[$];
  int sent_t[$], snt_t[$], ok_t[$];
  int ok_cnt, cyc = 0, tx_cnt, ridx, rwait, v;
  logic tx_act, clr_pend, snt_d, armed;
  logic [7:0] rval;

  remote_cmd_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .push_cmd(push_cmd), .full(full), .empty(empty),
    .snd_cmd(snd_cmd), .cmd(cmd), .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp),
    .clr_resp_rdy(clr_resp_rdy), .busy(busy), .cmd_ok(cmd_ok), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // transmitter: logs launches, clears cmd_snt one cycle late, finishes after a delay
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cmd_snt <= 0; tx_act <= 0; clr_pend <= 0; tx_cnt <= 0;
      sent.delete(); sent_t.delete();
    end else if (snd_cmd) begin
      sent.push_back(cmd); sent_t.push_back(cyc);
      clr_pend <= 1; tx_act <= 1;
      tx_cnt <= tx_fixed > 0 ? tx_fixed : int'($urandom_range(3, 30));
    end else begin
      if (clr_pend) begin cmd_snt <= 0; clr_pend <= 0; end
      if (tx_act && !hold_tx) begin
        if (tx_cnt == 0) begin cmd_snt <= 1; tx_act <= 0; end
        else tx_cnt <= tx_cnt - 1;
      end
    end

  // receiver: one planned reply per attempt (-1 = silence, default ACK)
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      resp_rdy <= 0; resp <= 0; ridx <= 0; rwait <= 0; armed <= 0; snt_d <= 0; rval <= 0; ok_cnt <= 0;
      snt_t.delete(); ok_t.delete();
    end else begin
      snt_d <= cmd_snt;
      if (cmd_ok) begin ok_cnt <= ok_cnt + 1; ok_t.push_back(cyc); end
      if (clr_resp_rdy) resp_rdy <= 0;
      if (cmd_snt && !snt_d) begin
        snt_t.push_back(cyc);
        v = ridx < plan.size() ? plan[ridx] : 'hA5;
        ridx <= ridx + 1;
        if (v >= 0) begin armed <= 1; rwait <= int'($urandom_range(1, 40)); rval <= v[7:0]; end
      end else if (armed) begin
        if (rwait == 0) begin resp_rdy <= 1; resp <= rval; armed <= 0; end
        else rwait <= rwait - 1;
      end
    end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 0; push = 0; hold_tx = 0; tx_fixed = 0;
    tick(3);
    rst_n = 1;
    tick(1);
  endtask

  task automatic push_word(input logic [15:0] w);
    int k = 0;
    while (full && k < 20000) begin tick(1); k++; end
    if (full) begin checks++; errors++; $display("FAIL push_wait full stayed high for %0d cycles", k); end
    push = 1; push_cmd = w;
    tick(1);
    push = 0;
  endtask

  task automatic wait_ok(input int n, input int bound, input string name);
    int k = 0;
    while (ok_cnt < n && k < bound) begin tick(1); k++; end
    checks++;
    if (ok_cnt < n) begin errors++; $display("FAIL %s_timeout cmd_ok count=%0d need=%0d", name, ok_cnt, n); end
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if ({snd_cmd, clr_resp_rdy, cmd_ok, err, busy, empty, full} !== 7'b0000010) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000010", {snd_cmd, clr_resp_rdy, cmd_ok, err, busy, empty, full});
    end
    checks++;
    if (cmd !== 16'h0) begin errors++; $display("FAIL reset_cmd got=%h exp=0000", cmd); end
  endtask

  task automatic test_single;
    do_reset;
    tx_fixed = 30; plan.delete();
    push = 1; push_cmd = 16'h2345;
    tick(1);
    push = 0;
    checks++;
    if ({empty, snd_cmd} !== 2'b00) begin errors++; $display("FAIL single_t1 empty,snd=%b exp=00", {empty, snd_cmd}); end
    tick(1);
    checks++;
    if (snd_cmd !== 1'b1 || cmd !== 16'h2345) begin errors++; $display("FAIL single_launch snd=%b cmd=%h exp=1 2345", snd_cmd, cmd); end
    wait_ok(1, 500, "single");
    tick(2);
    checks++;
    if ({empty, busy, err} !== 3'b100 || sent.size() != 1) begin
      errors++; $display("FAIL single_done empty,busy,err=%b sends=%0d exp=100 1", {empty, busy, err}, sent.size());
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] w[3] = '{16'h1111, 16'h2222, 16'h3333};
    do_reset;
    plan.delete();
    foreach (w[i]) push_word(w[i]);
    wait_ok(3, 2000, "b2b");
    tick(5);
    checks++;
    if (sent.size() != 3) begin errors++; $display("FAIL b2b_count sends=%0d exp=3", sent.size()); end
    for (int i = 0; i < 3 && i < sent.size(); i++) begin
      checks++;
      if (sent[i] !== w[i]) begin errors++; $display("FAIL b2b_order[%0d] got=%h exp=%h", i, sent[i], w[i]); end
    end
    for (int i = 1; i < 3 && i < sent.size() && i <= ok_t.size(); i++) begin
      checks++;
      if (sent_t[i] <= ok_t[i-1]) begin errors++; $display("FAIL b2b_overlap launch%0d at %0d before ack at %0d", i, sent_t[i], ok_t[i-1]); end
    end
  endtask

  task automatic test_nak;
    do_reset;
    plan = '{'h5A, 'hA5};
    push_word(16'hBEEF);
    wait_ok(1, 1000, "nak");
    tick(50);
    checks++;
    if (sent.size() != 2 || ok_cnt != 1 || err !== 1'b0) begin
      errors++; $display("FAIL nak_retry sends=%0d ok=%0d err=%b exp=2 1 0", sent.size(), ok_cnt, err);
    end else begin
      checks++;
      if (sent[0] !== 16'hBEEF || sent[1] !== 16'hBEEF) begin errors++; $display("FAIL nak_cmd got=%h,%h exp=beef", sent[0], sent[1]); end
    end
  endtask

  task automatic test_timeout;
    do_reset;
    plan = '{-1, -1, -1, -1};
    push_word(16'hDEAD);
    push_word(16'h0F0F);
    wait_ok(1, 3000, "tmo");
    tick(5);
    checks++;
    if (sent.size() != 5 || err !== 1'b1 || ok_cnt != 1) begin
      errors++; $display("FAIL tmo_drop sends=%0d err=%b ok=%0d exp=5 1 1", sent.size(), err, ok_cnt);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (sent[i] !== (i < 4 ? 16'hDEAD : 16'h0F0F)) begin errors++; $display("FAIL tmo_cmd[%0d] got=%h", i, sent[i]); end
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (sent_t[i] - snt_t[i-1] != TIMEOUT + 1) begin
          errors++; $display("FAIL tmo_gap[%0d] got=%0d exp=%0d", i, sent_t[i] - snt_t[i-1], TIMEOUT + 1);
        end
      end
    end
  endtask

  task automatic test_full;
    logic [15:0] w[5] = '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005};
    do_reset;
    plan.delete(); hold_tx = 1;
    foreach (w[i]) begin push = 1; push_cmd = w[i]; tick(1); end
    push = 0;
    checks++;
    if ({full, empty} !== 2'b10) begin errors++; $display("FAIL full_flag full,empty=%b exp=10", {full, empty}); end
    hold_tx = 0;
    wait_ok(DEPTH, 3000, "full");
    tick(300);
    checks++;
    if (sent.size() != DEPTH || ok_cnt != DEPTH) begin
      errors++; $display("FAIL full_count sends=%0d ok=%0d exp=%0d", sent.size(), ok_cnt, DEPTH);
    end
    for (int i = 0; i < DEPTH && i < sent.size(); i++) begin
      checks++;
      if (sent[i] !== w[i]) begin errors++; $display("FAIL full_order[%0d] got=%h exp=%h", i, sent[i], w[i]); end
    end
  endtask

  task automatic test_random;
    logic [15:0] exp_sent[$];
    logic [15:0] w;
    int exp_ok = 0, f, nb, k = 0;
    logic exp_err = 0;
    logic [15:0] words[8];
    do_reset;
    plan.delete();
    for (int i = 0; i < 8; i++) begin
      w = 16'($urandom);
      words[i] = w;
      f = $urandom_range(0, MAX_RETRY + 1);
      for (int j = 0; j < f; j++) begin
        nb = $urandom_range(0, 255);
        if (nb == 'hA5) nb = 0;
        plan.push_back($urandom_range(0, 1) ? -1 : nb);
      end
      if (f <= MAX_RETRY) begin plan.push_back('hA5); exp_ok++; end
      else exp_err = 1;
      for (int j = 0; j < (f <= MAX_RETRY ? f + 1 : MAX_RETRY + 1); j++) exp_sent.push_back(w);
    end
    foreach (words[i]) push_word(words[i]);
    while ((sent.size() < exp_sent.size() || busy || !empty) && k < 30000) begin tick(1); k++; end
    tick(5);
    checks++;
    if (sent.size() != exp_sent.size() || ok_cnt != exp_ok || err !== exp_err) begin
      errors++; $display("FAIL rand_totals sends=%0d/%0d ok=%0d/%0d err=%b/%b", sent.size(), exp_sent.size(), ok_cnt, exp_ok, err, exp_err);
    end
    for (int i = 0; i < exp_sent.size() && i < sent.size(); i++) begin
      checks++;
      if (sent[i] !== exp_sent[i]) begin errors++; $display("FAIL rand_seq[%0d] got=%h exp=%h", i, sent[i], exp_sent[i]); end
    end
  endtask

  task automatic test_reset_mid;
    int k = 0;
    do_reset;
    plan = '{-1};
    push_word(16'h7001); push_word(16'h7002); push_word(16'h7003);
    while (snt_t.size() < 1 && k < 500) begin tick(1); k++; end
    tick(5);
    checks++;
    if (busy !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL rstmid_pre busy=%b empty=%b exp=1 0", busy, empty); end
    rst_n = 0;
    #1;
    checks++;
    if ({snd_cmd, clr_resp_rdy, cmd_ok, err, busy, empty, full} !== 7'b0000010 || cmd !== 16'h0) begin
      errors++; $display("FAIL rstmid_async flags=%b cmd=%h exp=0000010 0000", {snd_cmd, clr_resp_rdy, cmd_ok, err, busy, empty, full}, cmd);
    end
    tick(2);
    rst_n = 1;
    tick(200);
    checks++;
    if (sent.size() != 0 || busy !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL rstmid_after sends=%0d busy=%b empty=%b exp=0 0 1", sent.size(), busy, empty);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_nak;
    test_timeout;
    test_full;
    test_random;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
